// File: rtl/sw_input_pkg.sv
// Shared register map, control-bit positions and defaults for the switch/button
// input peripheral.
package sw_input_pkg;

    typedef enum logic [1:0] {
        ADDR_STATE  = 2'd0,
        ADDR_EVENTS = 2'd1,
        ADDR_COUNT  = 2'd2,
        ADDR_CTRL   = 2'd3
    } reg_addr_e;

    // Fall events live in the upper half of the EVENTS word.
    localparam int unsigned FALL_BASE = 16;

    localparam int unsigned CTRL_IRQ_EN      = 0;
    localparam int unsigned CTRL_FALL_IRQ_EN = 1;

    // 10 ms at 12 MHz.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 120000;

endpackage

// File: rtl/sw_input_periph_debounce_cell.sv
// One input bit: two-flop synchroniser followed by a stable-count debouncer
// that emits single-cycle rise/fall pulses when the accepted level changes.
module debounce_cell
    import sw_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= pad_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Pulses are combinational so the parent can latch them on the same edge
    // that updates stable_q.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_o   = 1'b0;
        fall_o   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
            rise_o   = s2_q;
            fall_o   = ~s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/sw_input_periph.sv
// Memory-mapped switch/button input block: debounced levels, sticky W1C edge
// events, saturating press counter and a registered level interrupt.
module sw_input_periph
    import sw_input_pkg::*;
#(
    parameter int unsigned N_INPUTS        = 1,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_INPUTS-1:0] pad_in,
    input  logic                sel,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                irq,
    output logic [N_INPUTS-1:0] level
);

    logic [N_INPUTS-1:0] stable, rise_p, fall_p;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .pad_i   (pad_in[g]),
            .stable_o(stable[g]),
            .rise_o  (rise_p[g]),
            .fall_o  (fall_p[g])
        );
    end

    logic [N_INPUTS-1:0] rise_ev_q, rise_ev_d, fall_ev_q, fall_ev_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                irq_q, irq_d;
    logic                wr, rd;
    reg_addr_e           addr_e;
    logic                unused_wdata;

    assign addr_e       = reg_addr_e'(addr);
    assign wr           = sel & we;
    assign rd           = sel & ~we;
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_ev_q <= '0;
            fall_ev_q <= '0;
            count_q   <= '0;
            ctrl_q    <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            rise_ev_q <= rise_ev_d;
            fall_ev_q <= fall_ev_d;
            count_q   <= count_d;
            ctrl_q    <= ctrl_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rise_ev_d = rise_ev_q | rise_p;
        fall_ev_d = fall_ev_q | fall_p;
        count_d   = count_q;
        ctrl_d    = ctrl_q;
        rdata_d   = '0;

        // Hardware set is OR-ed in after the clear so it wins a collision.
        if (wr && addr_e == ADDR_EVENTS) begin
            rise_ev_d = (rise_ev_q & ~wdata[N_INPUTS-1:0]) | rise_p;
            fall_ev_d = (fall_ev_q & ~wdata[FALL_BASE +: N_INPUTS]) | fall_p;
        end

        if (wr && addr_e == ADDR_COUNT) begin
            count_d    = '0;
            count_d[0] = |rise_p;
        end else if (|rise_p && count_q != '1) begin
            count_d = count_q + 1'b1;
        end

        if (wr && addr_e == ADDR_CTRL) begin
            ctrl_d = wdata[1:0];
        end

        irq_d = ctrl_q[CTRL_IRQ_EN] &
                (|rise_ev_q | (ctrl_q[CTRL_FALL_IRQ_EN] & |fall_ev_q));

        if (rd) begin
            case (addr_e)
                ADDR_STATE:  rdata_d[N_INPUTS-1:0] = stable;
                ADDR_EVENTS: begin
                    rdata_d[N_INPUTS-1:0]          = rise_ev_q;
                    rdata_d[FALL_BASE +: N_INPUTS] = fall_ev_q;
                end
                ADDR_COUNT:  rdata_d[CNT_W-1:0] = count_q;
                ADDR_CTRL:   rdata_d[1:0]       = ctrl_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;
    assign level = stable;

endmodule

// File: tb/tb_sw_input_periph.sv
// Directed scoreboard bench for sw_input_periph (N_INPUTS=2, DEBOUNCE_CYCLES=4,
// CNT_W=4 so saturation is reachable in a short run).
module tb_sw_input_periph;
    import sw_input_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pad_in = 2'b11;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  level;

    sw_input_periph #(
        .N_INPUTS       (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pad_in(pad_in),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq),
        .level (level)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        sel = 1'b1; we = 1'b0; addr = a;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        tick(1);
        sel = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick(1);
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic press0();
        pad_in[0] = 1'b1; tick(7);
        pad_in[0] = 1'b0; tick(7);
    endtask

    // Monitor: one cycle after a read edge rdata must carry the queued value,
    // otherwise the bus must idle at zero.
    always @(posedge clk) rd_seen <= sel && !we && rst_n;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk(name_q.pop_front(), rdata, exp_q.pop_front());
            end
        end else begin
            chk("rdata_idle", rdata, 32'd0);
        end
    end

    initial begin
        // Reset with pads high
        tick(3);
        chk("rst_level", {30'd0, level}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        tick(5);
        chk("lvl_before_6", {30'd0, level}, 32'd0);
        tick(1);
        chk("lvl_at_6", {30'd0, level}, 32'd3);
        rd(ADDR_EVENTS, 32'h0000_0003, "rst_events");
        rd(ADDR_COUNT, 32'd1, "rst_count_once");
        rd(ADDR_STATE, 32'd3, "rst_state");
        pad_in = 2'b00;
        tick(8);
        rd(ADDR_EVENTS, 32'h0003_0003, "both_fall");
        wr(ADDR_EVENTS, 32'hFFFF_FFFF);
        wr(ADDR_COUNT, 32'h0);
        rd(ADDR_EVENTS, 32'h0, "events_cleared");
        rd(ADDR_COUNT, 32'h0, "count_cleared");

        // Glitch rejection
        pad_in[0] = 1'b1; tick(3);
        pad_in[0] = 1'b0; tick(10);
        chk("glitch_level", {30'd0, level}, 32'd0);
        rd(ADDR_EVENTS, 32'h0, "glitch_events");
        rd(ADDR_COUNT, 32'h0, "glitch_count");

        // Press / release
        pad_in[0] = 1'b1; tick(10);
        chk("press_level", {30'd0, level}, 32'd1);
        pad_in[0] = 1'b0; tick(10);
        rd(ADDR_EVENTS, 32'h0001_0001, "pr_events");
        rd(ADDR_COUNT, 32'd1, "pr_count");
        wr(ADDR_EVENTS, 32'h0000_0001);
        rd(ADDR_EVENTS, 32'h0001_0000, "w1c_rise");
        wr(ADDR_EVENTS, 32'hFFFF_FFFF);
        wr(ADDR_COUNT, 32'h0);

        // Interrupt
        wr(ADDR_CTRL, 32'h1);
        pad_in[1] = 1'b1; tick(5);
        chk("irq_lvl_pre", {30'd0, level}, 32'd0);
        tick(1);
        chk("irq_lvl_set", {30'd0, level}, 32'd2);
        chk("irq_not_yet", {31'd0, irq}, 32'd0);
        tick(1);
        chk("irq_assert", {31'd0, irq}, 32'd1);
        wr(ADDR_EVENTS, 32'h2);
        chk("irq_hold_clr", {31'd0, irq}, 32'd1);
        tick(1);
        chk("irq_deassert", {31'd0, irq}, 32'd0);
        pad_in[1] = 1'b0; tick(12);
        chk("irq_fall_masked", {31'd0, irq}, 32'd0);
        rd(ADDR_EVENTS, 32'h0002_0000, "fall1_event");
        wr(ADDR_CTRL, 32'h3);
        chk("irq_fall_pre", {31'd0, irq}, 32'd0);
        tick(1);
        chk("irq_fall_en", {31'd0, irq}, 32'd1);
        wr(ADDR_EVENTS, 32'hFFFF_FFFF);
        tick(1);
        chk("irq_fall_clr", {31'd0, irq}, 32'd0);
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_COUNT, 32'h0);

        // Collisions and read-vs-update ordering
        pad_in[0] = 1'b1; tick(5);
        wr(ADDR_EVENTS, 32'h1);
        chk("col_level", {30'd0, level}, 32'd1);
        rd(ADDR_EVENTS, 32'h1, "col_set_wins");
        rd(ADDR_COUNT, 32'd1, "col_count_a");
        pad_in[0] = 1'b0; tick(10);
        wr(ADDR_EVENTS, 32'hFFFF_FFFF);
        pad_in[0] = 1'b1; tick(5);
        wr(ADDR_COUNT, 32'h0);
        rd(ADDR_COUNT, 32'd1, "col_count_wr_inc");
        pad_in[0] = 1'b0; tick(5);
        rd(ADDR_EVENTS, 32'h0000_0001, "read_pre_update");
        rd(ADDR_EVENTS, 32'h0001_0001, "read_post_update");

        // Saturation (CNT_W=4)
        wr(ADDR_COUNT, 32'h0);
        for (int i = 0; i < 15; i++) press0();
        rd(ADDR_COUNT, 32'd15, "count_max");
        press0();
        rd(ADDR_COUNT, 32'd15, "count_saturate");

        // Bus behaviour
        wr(ADDR_STATE, 32'hFFFF_FFFF);
        rd(ADDR_STATE, 32'h0, "state_ro");
        wr(ADDR_CTRL, 32'hFFFF_FFFF);
        rd(ADDR_CTRL, 32'h3, "ctrl_mask");

        // Reset during a debounce window
        pad_in[0] = 1'b1; tick(4);
        rst_n = 1'b0; tick(1);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        tick(5);
        chk("mid_rst_lvl_pre", {30'd0, level}, 32'd0);
        tick(1);
        chk("mid_rst_lvl_6", {30'd0, level}, 32'd1);
        rd(ADDR_COUNT, 32'd1, "mid_rst_count");
        rd(ADDR_CTRL, 32'h0, "mid_rst_ctrl");

        tick(2);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
